// File: rtl/mod_n_stream_checker_pkg.sv
// Shared definitions for the mod-N stream checker: frame state encoding and
// a single-bit modular step used by the checker and its reference models.
package mod_n_stream_checker_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // One MSB-first step: shift the remainder left, add the new bit, fold once.
   function automatic int modStep(input int r, input logic b, input int divisor);
      int t;
      t = r + r + {31'b0, b};
      return (t >= divisor) ? (t - divisor) : t;
   endfunction

endpackage

// File: rtl/mod_n_stream_checker_mod_step.sv
// Combinational single-bit remainder step: r_out = (2*r_in + bit_in) mod DIVISOR,
// valid because r_in < DIVISOR keeps the shifted value below 2*DIVISOR.
module mod_step
   import mod_n_stream_checker_pkg::*;
#(
   parameter  int DIVISOR = 5,
   localparam int REM_W   = $clog2(DIVISOR)
) (
   input  logic [REM_W-1:0] r_in,
   input  logic             bit_in,
   output logic [REM_W-1:0] r_out
);

   localparam logic [REM_W:0] DIV_W = (REM_W+1)'(DIVISOR);

   logic [REM_W:0] w_shift;
   logic [REM_W:0] w_diff;

   assign w_shift = {r_in, bit_in};
   assign w_diff  = w_shift - DIV_W;
   assign r_out   = (w_shift >= DIV_W) ? w_diff[REM_W-1:0] : w_shift[REM_W-1:0];

endmodule

// File: rtl/mod_n_stream_checker.sv
// Streams an MSB-first number BITS bits per beat and tracks its value modulo
// DIVISOR, with per-beat divisibility and a registered end-of-frame result.
module mod_n_stream_checker
   import mod_n_stream_checker_pkg::*;
#(
   parameter  int DIVISOR = 5,
   parameter  int BITS    = 1,
   localparam int REM_W   = $clog2(DIVISOR)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [BITS-1:0]  in_data,
   input  logic             in_last,
   output logic [REM_W-1:0] rem_out,
   output logic             started,
   output logic             divisible,
   output logic             result_valid,
   output logic [REM_W-1:0] result_rem,
   output logic             result_div
);

   state_t           r_state;
   logic [REM_W-1:0] r_remainder;
   logic             r_divisible;
   logic             r_resultValid;
   logic [REM_W-1:0] r_resultRem;
   logic             r_resultDiv;

   logic [REM_W-1:0] w_chain [BITS+1];
   logic [REM_W-1:0] w_nextRem;

   // A clear arriving with a beat makes that beat the first of a new frame.
   assign w_chain[0] = (clear || (r_state == INIT)) ? '0 : r_remainder;

   for (genvar i = 0; i < BITS; i++) begin : gStep
      mod_step #(.DIVISOR(DIVISOR)) uStep (
         .r_in   (w_chain[i]),
         .bit_in (in_data[BITS-1-i]),
         .r_out  (w_chain[i+1])
      );
   end

   assign w_nextRem = w_chain[BITS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= INIT;
         r_remainder   <= '0;
         r_divisible   <= 1'b0;
         r_resultValid <= 1'b0;
         r_resultRem   <= '0;
         r_resultDiv   <= 1'b0;
      end else begin
         r_resultValid <= in_valid && in_last;
         if (in_valid) begin
            if (in_last) begin
               r_resultRem <= w_nextRem;
               r_resultDiv <= (w_nextRem == '0);
               r_state     <= INIT;
               r_remainder <= '0;
               r_divisible <= 1'b0;
            end else begin
               r_state     <= RUN;
               r_remainder <= w_nextRem;
               r_divisible <= (w_nextRem == '0);
            end
         end else if (clear) begin
            r_state     <= INIT;
            r_remainder <= '0;
            r_divisible <= 1'b0;
         end
      end
   end

   assign rem_out      = r_remainder;
   assign started      = (r_state == RUN);
   assign divisible    = r_divisible;
   assign result_valid = r_resultValid;
   assign result_rem   = r_resultRem;
   assign result_div   = r_resultDiv;

endmodule
